// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
//   HDR_BYTES      : bytes in the little-endian word-count header
//   LANE_W         : width of the byte-lane counter
//   accepts_bytes(): states in which the loader takes stream bytes
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian stream bytes into instruction words.
//   clk, reset : clock and asynchronous active-low reset
//   data_xfer  : a data byte is transferred this cycle
//   byte_data  : the transferred byte
//   lane       : index of the next byte within the current word
//   we         : one-cycle write strobe, the cycle after the last byte of a word
//   wdata      : assembled word, valid while we is high (held afterwards)
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int datasize = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_xfer,
  input  logic [7:0]          byte_data,
  output logic [LANE_W-1:0]   lane,
  output logic                we,
  output logic [datasize-1:0] wdata
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0]   lane_q,  lane_d;
  logic [datasize-9:0] shift_q, shift_d;
  logic                we_q,    we_d;
  logic [datasize-1:0] wdata_q, wdata_d;

  // NOTE: every next-state signal gets a default before any branch; a path
  // that leaves one unassigned would make always_comb infer a latch.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    if (data_xfer) begin
      if (lane_q == LAST_LANE) begin
        wdata_d = {byte_data, shift_q};
        we_d    = 1'b1;
        lane_d  = '0;
      end else begin
        // Bytes enter at the top and slide down, so byte0 ends at bits 7:0.
        shift_d = {byte_data, shift_q[datasize-9:8]};
        lane_d  = lane_q + LANE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q  <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign lane  = lane_q;
  assign we    = we_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams an instruction image into
// instruction memory and releases the core once the checksum matches.
//   clk, reset  : clock and asynchronous active-low reset
//   byte_valid  : source offers byte_data this cycle
//   byte_data   : stream byte (count lo/hi, 4*N data bytes, XOR checksum)
//   byte_ready  : loader accepts a byte this cycle
//   imem_we     : one-cycle instruction-memory write strobe
//   imem_addr   : word address of the write
//   imem_wdata  : word being written
//   core_reset  : active-low core reset, released after a verified load
//   load_done   : image loaded and checksum matched (sticky)
//   load_error  : oversize image or checksum mismatch (sticky)
//   word_count  : words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int datasize = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [datasize-1:0] imem_wdata,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_error,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t          state_q,      state_d;
  logic [15:0]     count_q,      count_d;
  logic [7:0]      chk_q,        chk_d;
  logic [ADDR_W:0] wr_idx_q,     wr_idx_d;
  logic            byte_ready_q, byte_ready_d;
  logic            core_reset_q, core_reset_d;
  logic            load_done_q,  load_done_d;
  logic            load_error_q, load_error_d;

  logic              xfer;
  logic              data_xfer;
  logic [15:0]       n_hdr;
  logic [LANE_W-1:0] lane;

  assign xfer      = byte_valid && byte_ready_q;
  assign data_xfer = xfer && (state_q == DATA);
  assign n_hdr     = {byte_data, count_q[7:0]};

  word_assembler #(.datasize(datasize)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .data_xfer (data_xfer),
    .byte_data (byte_data),
    .lane      (lane),
    .we        (imem_we),
    .wdata     (imem_wdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    chk_d    = chk_q;
    unique case (state_q)
      IDLE:   state_d = HDR_LO;
      HDR_LO: if (xfer) begin
        count_d[7:0] = byte_data;
        state_d      = HDR_HI;
      end
      HDR_HI: if (xfer) begin
        count_d[15:8] = byte_data;
        if ({1'b0, n_hdr} > CAPACITY) state_d = ERR;
        else if (n_hdr == 16'd0)      state_d = CHK;
        else                          state_d = DATA;
      end
      DATA: if (xfer) begin
        chk_d = chk_q ^ byte_data;
        // Byte-3 transfers are four cycles apart, so the previous word's write
        // has already advanced wr_idx_q: it indexes the word closing now.
        if (lane == LANE_W'(BYTES_PER_WORD - 1) && 16'(wr_idx_q) + 16'd1 == count_q)
          state_d = CHK;
      end
      CHK: if (xfer) state_d = (byte_data == chk_q) ? RUN : ERR;
      RUN, ERR: state_d = state_q;
      default:  state_d = IDLE;
    endcase

    wr_idx_d = imem_we ? wr_idx_q + (ADDR_W+1)'(1) : wr_idx_q;

    // Looking at state_d drops ready in the cycle right after the final byte;
    // gating on IDLE delays the first rise by one cycle after reset release.
    byte_ready_d = (state_q != IDLE) && accepts_bytes(state_d);
    core_reset_d = (state_d == RUN);
    load_done_d  = (state_d == RUN);
    load_error_d = (state_d == ERR);
  end

  // NOTE: reset clears every register here, datapath included, so a reset
  // mid-load leaves no stale header or checksum. The instruction memory itself
  // lives outside this block and is deliberately not cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      chk_q        <= '0;
      wr_idx_q     <= '0;
      byte_ready_q <= 1'b0;
      core_reset_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      chk_q        <= chk_d;
      wr_idx_q     <= wr_idx_d;
      byte_ready_q <= byte_ready_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_addr  = wr_idx_q[ADDR_W-1:0];
  assign word_count = wr_idx_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W), .datasize(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // Records every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  64'(byte_ready), 64'(0));
    check({tag, "_we"},     64'(imem_we),    64'(0));
    check({tag, "_addr"},   64'(imem_addr),  64'(0));
    check({tag, "_wdata"},  64'(imem_wdata), 64'(0));
    check({tag, "_core"},   64'(core_reset), 64'(0));
    check({tag, "_done"},   64'(load_done),  64'(0));
    check({tag, "_err"},    64'(load_error), 64'(0));
    check({tag, "_wcount"}, 64'(word_count), 64'(0));
  endtask

  // Async reset, checks reset values, releases, and checks the ready delay.
  task automatic do_reset(input string tag);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reset      = 1'b0;
    #1;
    check_reset_vals(tag);
    step();
    step();
    check_reset_vals({tag, "_held"});
    reset = 1'b1;
    step();
    check({tag, "_ready_edge1"}, 64'(byte_ready), 64'(0));
    step();
    check({tag, "_ready_edge2"}, 64'(byte_ready), 64'(1));
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Offers one byte after 'gap' idle cycles; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    while (!byte_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'(1));
    step();
    byte_valid = 1'b0;
  endtask

  task automatic load_test1(input logic [7:0] chk);
    stream = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h0C, 8'h00, 8'h09, 8'h20, chk};
  endtask

  task automatic check_writes2(input string tag);
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(2));
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, 64'(wr_addr[0]), 64'(0));
      check({tag, "_d0"}, 64'(wr_data[0]), 64'h20080005);
      check({tag, "_a1"}, 64'(wr_addr[1]), 64'(1));
      check({tag, "_d1"}, 64'(wr_data[1]), 64'h2009000C);
    end
    check({tag, "_wcount"}, 64'(word_count), 64'(2));
  endtask

  int gap_tab[11] = '{0, 2, 1, 3, 0, 1, 2, 3, 1, 0, 2};

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Test 1: good two-word image, back to back.
    do_reset("t1_rst");
    load_test1(8'h08);
    for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
    check("t1_core_before_chk", 64'(core_reset), 64'(0));
    check("t1_done_before_chk", 64'(load_done), 64'(0));
    send_byte(stream[10], 0);
    check("t1_core", 64'(core_reset), 64'(1));
    check("t1_done", 64'(load_done), 64'(1));
    check("t1_err", 64'(load_error), 64'(0));
    check("t1_ready", 64'(byte_ready), 64'(0));
    step();
    step();
    check_writes2("t1");
    check("t1_core_sticky", 64'(core_reset), 64'(1));

    // Test 2: checksum mismatch; trailing bytes must be ignored.
    do_reset("t2_rst");
    load_test1(8'h09);
    for (int i = 0; i < 11; i++) send_byte(stream[i], 0);
    check("t2_err", 64'(load_error), 64'(1));
    check("t2_core", 64'(core_reset), 64'(0));
    check("t2_done", 64'(load_done), 64'(0));
    check("t2_ready", 64'(byte_ready), 64'(0));
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (6) step();
    byte_valid = 1'b0;
    step();
    check_writes2("t2");
    check("t2_err_sticky", 64'(load_error), 64'(1));
    check("t2_ready_after", 64'(byte_ready), 64'(0));

    // Test 3: empty image.
    do_reset("t3_rst");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t3_done", 64'(load_done), 64'(1));
    check("t3_core", 64'(core_reset), 64'(1));
    check("t3_err", 64'(load_error), 64'(0));
    step();
    check("t3_nwr", 64'(wr_addr.size()), 64'(0));
    check("t3_wcount", 64'(word_count), 64'(0));

    // Test 4a: N=257 exceeds 256-word capacity.
    do_reset("t4_rst");
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t4_err", 64'(load_error), 64'(1));
    check("t4_ready", 64'(byte_ready), 64'(0));
    check("t4_core", 64'(core_reset), 64'(0));
    repeat (3) step();
    check("t4_nwr", 64'(wr_addr.size()), 64'(0));

    // Test 4b: N=256 exactly fills memory and is accepted.
    do_reset("t4b_rst");
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    check("t4b_err", 64'(load_error), 64'(0));
    check("t4b_ready", 64'(byte_ready), 64'(1));

    // Test 5: test 1 with idle gaps, plus a long pause inside word 1.
    do_reset("t5_rst");
    load_test1(8'h08);
    for (int i = 0; i < 11; i++) begin
      send_byte(stream[i], gap_tab[i]);
      if (i == 6) begin
        check("t5_wcount_pre_gap", 64'(word_count), 64'(1));
        repeat (4) step();
        check("t5_wcount_in_gap", 64'(word_count), 64'(1));
        check("t5_nwr_in_gap", 64'(wr_addr.size()), 64'(1));
        check("t5_ready_in_gap", 64'(byte_ready), 64'(1));
      end
    end
    check("t5_done", 64'(load_done), 64'(1));
    check("t5_core", 64'(core_reset), 64'(1));
    step();
    step();
    check_writes2("t5");

    // Test 6: reset after five bytes, then a full reload.
    do_reset("t6_rst");
    load_test1(8'h08);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    check("t6_nwr_partial", 64'(wr_addr.size()), 64'(0));
    do_reset("t6_midrst");
    for (int i = 0; i < 11; i++) send_byte(stream[i], 0);
    check("t6_done", 64'(load_done), 64'(1));
    check("t6_core", 64'(core_reset), 64'(1));
    step();
    step();
    check_writes2("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader sitting directly upstream of the pipelined MIPS core. It accepts a byte stream over a valid/ready handshake: a word-count header, little-endian 32-bit instruction words, then an XOR checksum. It writes each assembled word into instruction memory at consecutive word addresses. It holds the core in reset until the image is verified, then releases it; on a checksum or size error it latches an error and never releases the core.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- datasize, 32, instruction word width; only 32 is supported
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears every register
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept; a transfer occurs on a cycle with byte_valid && byte_ready
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of current write
- imem_wdata  out  datasize  assembled instruction word
- core_reset  out  1  active-low reset to the core; 0 until load verified
- load_done  out  1  image loaded and checksum matched (sticky)
- load_error  out  1  size or checksum error (sticky)
- word_count  out  ADDR_W+1  words written so far

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4·N data bytes (per word byte0 = bits 7:0 … byte3 = bits 31:24), then CHK = XOR of all 4·N data bytes. Header bytes are excluded from CHK.
- FSM states: IDLE, HDR_LO, HDR_HI, DATA, CHK, RUN, ERR.
  - IDLE→HDR_LO unconditionally on the first clock after reset release.
  - HDR_LO→HDR_HI on a transfer.
  - HDR_HI: on a transfer, N > 2^ADDR_W goes to ERR, N == 0 goes to CHK, otherwise DATA.
  - DATA→CHK on the transfer of the 4·N-th data byte.
  - CHK: on a transfer, a match goes to RUN and a mismatch goes to ERR.
  - RUN and ERR are terminal; they are left only via reset.
- byte_ready is 1 in HDR_LO, HDR_HI, DATA and CHK, and 0 in IDLE, RUN and ERR. There is no internal back-pressure, so back-to-back transfers are accepted every cycle.
- Data path:
  - A 2-bit byte lane counter and a 24-bit shift register collect bytes 0–2.
  - On the byte-3 transfer, the word {byte_data, shift[23:0]} is registered into imem_wdata. imem_we pulses the next cycle with imem_addr = the current word index.
  - The word index and word_count increment with the write.
- The running XOR accumulator updates on every DATA transfer only.
- Gaps (byte_valid low) freeze all counters and state; partial words are held indefinitely.
- Reset mid-load discards everything: address returns to 0, and the next load restarts from the header. Memory contents are not cleared.

## Timing
- Reset values: byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 0, load_done 0, load_error 0, word_count 0, state IDLE.
- byte_ready rises on the second rising edge after reset deassertion (IDLE→HDR_LO, then registered).
- Write latency: imem_we is high exactly one cycle, the cycle after the byte-3 transfer. The final write may coincide with the CHK transfer; the final write must still occur.
- CHK transfer at cycle t: in cycle t+1, core_reset=1 and load_done=1 (match), or load_error=1 (mismatch). byte_ready=0 from t+1.
- Size error: load_error=1 and byte_ready=0 the cycle after the CNT_HI transfer; no writes occur.
- core_reset and load_done never deassert, and load_error never clears, except by reset.
- All outputs are registered; there is no combinational path from byte_valid or byte_data to any output.

## Structure
- Package imem_loader_pkg holds the state enum, BYTES_PER_WORD=4 and the header byte count.
- One sub-module, word_assembler, contains the lane counter, shift register and write-strobe generation. The FSM, counters and checksum stay in the top level.

## Test plan
- N=2, stream 02 00 05 00 08 20 0C 00 09 20 08, back-to-back → writes addr0=0x20080005 and addr1=0x2009000C, word_count=2. core_reset=1 and load_done=1 the cycle after the 0x08 transfer.
- Same stream with CHK=0x09 → both writes occur, then load_error=1, core_reset stays 0, byte_ready=0, and further bytes are ignored.
- N=0, stream 00 00 00 → no imem_we, load_done=1, core_reset=1.
- ADDR_W=8, header 01 01 (N=257) → load_error=1 after CNT_HI, zero writes, byte_ready=0.
- Test 1 with random 0–3-cycle gaps in byte_valid → identical writes and checksum result; counters are frozen during gaps.
- Assert reset after 5 bytes of test 1, release, then resend the full stream → all outputs are at reset values during reset, writes restart at addr0, and load_done=1 at the end.
